// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
//
// Shared types and constants for the pipeline hazard controller.
//   ctrl_state_t : controller FSM states (RUN, MDU_WAIT, MEM_WAIT)
//   act_t        : the single pipeline action chosen in a cycle after
//                  priority resolution
//   REG_W_DEFAULT: default register index width (RV32: 32 registers)
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam int REG_W_DEFAULT = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MDU_WAIT = 2'd1,
        MEM_WAIT = 2'd2
    } ctrl_state_t;

    // Exactly one of these is applied per cycle.
    typedef enum logic [2:0] {
        ACT_NONE     = 3'd0,
        ACT_RESET    = 3'd1,
        ACT_TIMEOUT  = 3'd2,
        ACT_MEM      = 3'd3,
        ACT_MDU      = 3'd4,
        ACT_MDU_DONE = 3'd5,
        ACT_BRANCH   = 3'd6,
        ACT_LOADUSE  = 3'd7
    } act_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
//
// Bundle between the pipeline datapath and the hazard controller.
//   master : pipeline side. Drives hazard sources (register indices, load,
//            branch, MDU and data-memory status), receives stall/flush
//            controls, the timeout pulse and the performance counters.
//   slave  : hazard controller side (the mirror of master).
// Parameters: REG_W register index width, CNT_W counter width.
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = REG_W_DEFAULT,
    parameter int CNT_W = 32
);

    logic [REG_W-1:0] rs1_id;
    logic [REG_W-1:0] rs2_id;
    logic             use_rs1_id;
    logic             use_rs2_id;
    logic [REG_W-1:0] rd_ex;
    logic             memread_ex;
    logic             branch_taken_ex;
    logic             mdu_start_ex;
    logic             mdu_done;
    logic             dmem_req_mem;
    logic             dmem_ready;

    logic             pc_stall;
    logic             if_id_stall;
    logic             id_ex_stall;
    logic             ex_mem_stall;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_flush;
    logic             mem_wb_flush;
    logic             mem_timeout;
    logic [CNT_W-1:0] cnt_loaduse;
    logic [CNT_W-1:0] cnt_flush;
    logic [CNT_W-1:0] cnt_stall;

    modport master (
        output rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_ex, memread_ex,
               branch_taken_ex, mdu_start_ex, mdu_done, dmem_req_mem, dmem_ready,
        input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
               if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
               mem_timeout, cnt_loaduse, cnt_flush, cnt_stall
    );

    modport slave (
        input  rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_ex, memread_ex,
               branch_taken_ex, mdu_start_ex, mdu_done, dmem_req_mem, dmem_ready,
        output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
               if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
               mem_timeout, cnt_loaduse, cnt_flush, cnt_stall
    );

endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect
//
// Combinational load-use hazard detector. Flags the case where the
// instruction in EX is a load whose destination is read by the instruction
// in ID; forwarding cannot cover it because the load data only exists after
// MEM.
//   rd, memread        : destination and load flag of the EX instruction
//   rs1/rs2, use_rs1/2 : sources of the ID instruction and whether read
//   load_use           : hazard present
//   rd_nonzero         : destination is not x0 (usable on its own as the
//                        x0 guard by other hazard logic)
// ---------------------------------------------------------------------------
module load_use_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = REG_W_DEFAULT
) (
    input  logic [REG_W-1:0] rd,
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    input  logic             use_rs1,
    input  logic             use_rs2,
    input  logic             memread,
    output logic             load_use,
    output logic             rd_nonzero
);

    // x0 is hardwired to zero, so a load targeting it creates no dependency.
    assign rd_nonzero = |rd;

    assign load_use = memread && rd_nonzero &&
                      ((use_rs1 && (rd == rs1)) || (use_rs2 && (rd == rs2)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Central stall/flush sequencer for the 5-stage pipeline. Each cycle one
// action is chosen by priority: memory wait > MDU > branch > load-use.
// Stall/flush controls are combinational from the registered state and the
// current inputs, so they act in the same cycle.
//
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous, active-high; clears the pipe (all flushes high)
//   bus    : pipe_hazard_ctrl_if.slave (hazard sources in, controls out)
//
// Parameters:
//   REG_W       register index width
//   MEM_TIMEOUT consecutive memory wait cycles before abort (>= 2)
//   CNT_W       performance counter width
//
// Build option:
//   PIPE_PERF_CNT_EN  when defined, builds saturating load-use / redirect /
//                     stall-cycle counters; otherwise the counter outputs
//                     are tied to zero.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W       = REG_W_DEFAULT,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input logic              clk,
    input logic              reset,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

    ctrl_state_t       state;
    ctrl_state_t       state_next;
    logic [WCNT_W-1:0] wait_cnt;
    logic [WCNT_W-1:0] wait_cnt_next;
    logic              mdu_pend;
    logic              mdu_pend_next;
    act_t              act;

    logic load_use;
    logic rd_nonzero;
    logic mem_wait;
    logic timeout_hit;
    logic mdu_busy;

    logic pc_stall;
    logic if_id_stall;
    logic id_ex_stall;
    logic ex_mem_stall;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic mem_wb_flush;
    logic mem_timeout;

    load_use_detect #(
        .REG_W(REG_W)
    ) u_load_use (
        .rd         (bus.rd_ex),
        .rs1        (bus.rs1_id),
        .rs2        (bus.rs2_id),
        .use_rs1    (bus.use_rs1_id),
        .use_rs2    (bus.use_rs2_id),
        .memread    (bus.memread_ex),
        .load_use   (load_use),
        .rd_nonzero (rd_nonzero)
    );

    assign mem_wait    = bus.dmem_req_mem && !bus.dmem_ready;
    assign timeout_hit = (state == MEM_WAIT) && mem_wait &&
                         (wait_cnt == WCNT_W'(MEM_TIMEOUT));
    // An MDU operation is outstanding either in MDU_WAIT itself or while a
    // memory wait has temporarily taken over from it (mdu_pend remembers it).
    assign mdu_busy    = (state == MDU_WAIT) || ((state == MEM_WAIT) && mdu_pend);

    // Priority resolution: pick the single action for this cycle. mdu_done
    // only matters while an MDU operation is outstanding, and mdu_start_ex is
    // only taken when none is.
    always_comb begin
        act = ACT_NONE;
        if (reset) begin
            act = ACT_RESET;
        end else if (timeout_hit) begin
            act = ACT_TIMEOUT;
        end else if (mem_wait) begin
            act = ACT_MEM;
        end else if (mdu_busy) begin
            act = bus.mdu_done ? ACT_MDU_DONE : ACT_MDU;
        end else if (bus.mdu_start_ex) begin
            act = ACT_MDU;
        end else if (bus.branch_taken_ex) begin
            act = ACT_BRANCH;
        end else if (load_use) begin
            act = ACT_LOADUSE;
        end
    end

    // Map the chosen action onto the per-register controls. No action ever
    // stalls and flushes the same pipeline register.
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        ex_mem_stall = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        mem_timeout  = 1'b0;
        case (act)
            ACT_RESET: begin
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
                mem_wb_flush = 1'b1;
            end
            ACT_TIMEOUT: begin
                mem_timeout  = 1'b1;
                ex_mem_flush = 1'b1;
                mem_wb_flush = 1'b1;
            end
            ACT_MEM: begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_stall = 1'b1;
                mem_wb_flush = 1'b1;
            end
            ACT_MDU: begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_flush = 1'b1;
            end
            ACT_BRANCH: begin
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
            end
            ACT_LOADUSE: begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_flush  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Next-state logic. The wait counter starts at 1 on the first stalled
    // memory cycle so that it equals the number of wait cycles already
    // spent. A timeout abandons everything in flight and returns to RUN.
    always_comb begin
        state_next    = RUN;
        wait_cnt_next = '0;
        mdu_pend_next = 1'b0;
        case (act)
            ACT_MEM: begin
                state_next    = MEM_WAIT;
                wait_cnt_next = (state == MEM_WAIT) ? wait_cnt + WCNT_W'(1) : WCNT_W'(1);
                mdu_pend_next = mdu_busy;
            end
            ACT_MDU: begin
                state_next    = MDU_WAIT;
            end
            default: begin
                state_next    = RUN;
            end
        endcase
    end

    // State registers; reset abandons any outstanding MDU or memory wait.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= '0;
            mdu_pend <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            mdu_pend <= mdu_pend_next;
        end
    end

    assign bus.pc_stall     = pc_stall;
    assign bus.if_id_stall  = if_id_stall;
    assign bus.id_ex_stall  = id_ex_stall;
    assign bus.ex_mem_stall = ex_mem_stall;
    assign bus.if_id_flush  = if_id_flush;
    assign bus.id_ex_flush  = id_ex_flush;
    assign bus.ex_mem_flush = ex_mem_flush;
    assign bus.mem_wb_flush = mem_wb_flush;
    assign bus.mem_timeout  = mem_timeout;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_loaduse_q;
    logic [CNT_W-1:0] cnt_flush_q;
    logic [CNT_W-1:0] cnt_stall_q;

    // Saturating event counters: each stops at all-ones rather than wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_loaduse_q <= '0;
            cnt_flush_q   <= '0;
            cnt_stall_q   <= '0;
        end else begin
            if ((act == ACT_LOADUSE) && (cnt_loaduse_q != {CNT_W{1'b1}}))
                cnt_loaduse_q <= cnt_loaduse_q + CNT_W'(1);
            if ((act == ACT_BRANCH) && (cnt_flush_q != {CNT_W{1'b1}}))
                cnt_flush_q <= cnt_flush_q + CNT_W'(1);
            if (pc_stall && (cnt_stall_q != {CNT_W{1'b1}}))
                cnt_stall_q <= cnt_stall_q + CNT_W'(1);
        end
    end

    assign bus.cnt_loaduse = cnt_loaduse_q;
    assign bus.cnt_flush   = cnt_flush_q;
    assign bus.cnt_stall   = cnt_stall_q;
`else
    assign bus.cnt_loaduse = {CNT_W{1'b0}};
    assign bus.cnt_flush   = {CNT_W{1'b0}};
    assign bus.cnt_stall   = {CNT_W{1'b0}};
`endif

    // rd_nonzero is already folded into load_use; kept visible for reuse.
    logic unused_ok;
    assign unused_ok = rd_nonzero;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Self-checking bench for pipe_hazard_ctrl (MEM_TIMEOUT = 4). Each stimulus
// cycle pushes its expected control vector onto a scoreboard queue; a
// monitor on the falling edge pops and compares it, and also checks the
// performance counters against a count of the expected events (zero when
// PIPE_PERF_CNT_EN is not defined).
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    // Control vector bit order:
    // {pc_st, if_id_st, id_ex_st, ex_mem_st, if_id_fl, id_ex_fl, ex_mem_fl, mem_wb_fl, timeout}
    localparam logic [8:0] C_NONE = 9'b0000_0000_0;
    localparam logic [8:0] C_LU   = 9'b1100_0100_0;
    localparam logic [8:0] C_BR   = 9'b0000_1100_0;
    localparam logic [8:0] C_MDU  = 9'b1110_0010_0;
    localparam logic [8:0] C_MEMW = 9'b1111_0001_0;
    localparam logic [8:0] C_TO   = 9'b0000_0011_1;
    localparam logic [8:0] C_RST  = 9'b0000_1111_0;

    typedef struct {
        string      name;
        logic [8:0] ctl;
        logic       rst;
    } exp_t;

    logic clk;
    logic reset;

    exp_t sb_q[$];
    exp_t cur;

    int n_compared   = 0;
    int n_mismatched = 0;

    int  m_lu = 0;
    int  m_fl = 0;
    int  m_st = 0;
    logic cnt_valid = 1'b0;

    logic [8:0] obs_ctl;

    pipe_hazard_ctrl_if #(.REG_W(5), .CNT_W(32)) bus ();

    pipe_hazard_ctrl #(
        .REG_W      (5),
        .MEM_TIMEOUT(4),
        .CNT_W      (32)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Clock starts high so the first falling edge samples the first stimulus.
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    assign obs_ctl = {bus.pc_stall, bus.if_id_stall, bus.id_ex_stall, bus.ex_mem_stall,
                      bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush, bus.mem_wb_flush,
                      bus.mem_timeout};

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, record the expected result, advance a cycle.
    task automatic applyStimulus(input string tag, input int rst,
                                 input int rs1, input int rs2, input int rd,
                                 input int u1, input int u2, input int mr, input int br,
                                 input int ms, input int md, input int req, input int rdy,
                                 input logic [8:0] exp);
        exp_t e;
        reset               = 1'(rst);
        bus.rs1_id          = 5'(rs1);
        bus.rs2_id          = 5'(rs2);
        bus.rd_ex           = 5'(rd);
        bus.use_rs1_id      = 1'(u1);
        bus.use_rs2_id      = 1'(u2);
        bus.memread_ex      = 1'(mr);
        bus.branch_taken_ex = 1'(br);
        bus.mdu_start_ex    = 1'(ms);
        bus.mdu_done        = 1'(md);
        bus.dmem_req_mem    = 1'(req);
        bus.dmem_ready      = 1'(rdy);
        e.name = tag;
        e.ctl  = exp;
        e.rst  = 1'(rst);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare controls for the cycle, then counters accumulated by
    // the edges before it, then account for this cycle's events.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            cur = sb_q.pop_front();
            checkOutput({cur.name, ":ctl"}, 32'(obs_ctl), 32'(cur.ctl));
            if (cnt_valid) begin
                checkOutput({cur.name, ":cnt_loaduse"}, bus.cnt_loaduse, 32'(m_lu));
                checkOutput({cur.name, ":cnt_flush"},   bus.cnt_flush,   32'(m_fl));
                checkOutput({cur.name, ":cnt_stall"},   bus.cnt_stall,   32'(m_st));
            end
            if (cur.rst) begin
                m_lu = 0;
                m_fl = 0;
                m_st = 0;
                cnt_valid = 1'b1;
            end else begin
`ifdef PIPE_PERF_CNT_EN
                if (cur.ctl == C_LU) m_lu++;
                if (cur.ctl == C_BR) m_fl++;
                if (cur.ctl[8])      m_st++;
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        //             tag            rst rs1 rs2 rd u1 u2 mr br ms md rq rdy  expected
        applyStimulus("rst0",         1,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST);
        applyStimulus("rst1",         1,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST);
        applyStimulus("idle",         0,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE);

        applyStimulus("lu_rs1",       0,  5,  0,  5, 1, 0, 1, 0, 0, 0, 0, 0, C_LU);
        applyStimulus("lu_after",     0,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE);
        applyStimulus("lu_x0",        0,  0,  0,  0, 1, 0, 1, 0, 0, 0, 0, 0, C_NONE);
        applyStimulus("lu_rs2",       0,  3,  7,  7, 0, 1, 1, 0, 0, 0, 0, 0, C_LU);
        applyStimulus("lu_nouse",     0,  7,  7,  7, 0, 0, 1, 0, 0, 0, 0, 0, C_NONE);
        applyStimulus("lu_noload",    0,  5,  0,  5, 1, 0, 0, 0, 0, 0, 0, 0, C_NONE);
        applyStimulus("lu_diffreg",   0,  6,  4,  5, 1, 1, 1, 0, 0, 0, 0, 0, C_NONE);

        applyStimulus("br_lu",        0,  5,  0,  5, 1, 0, 1, 1, 0, 0, 0, 0, C_BR);
        applyStimulus("br_after",     0,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE);

        applyStimulus("mdu_start",    0,  0,  0,  0, 0, 0, 0, 0, 1, 0, 0, 0, C_MDU);
        for (int i = 0; i < 3; i++)
            applyStimulus("mdu_wait", 0,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, C_MDU);
        applyStimulus("mdu_done",     0,  0,  0,  0, 0, 0, 0, 0, 0, 1, 0, 0, C_NONE);
        applyStimulus("mdu_run",      0,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE);
        applyStimulus("mdu_done_ign", 0,  5,  0,  5, 1, 0, 1, 0, 0, 1, 0, 0, C_LU);

        for (int i = 0; i < 3; i++)
            applyStimulus("memw",     0,  0,  0,  0, 0, 0, 0, 0, 0, 0, 1, 0, C_MEMW);
        applyStimulus("mem_ready",    0,  0,  0,  0, 0, 0, 0, 0, 0, 0, 1, 1, C_NONE);
        applyStimulus("mem_idle",     0,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE);

        for (int i = 0; i < 4; i++)
            applyStimulus("to_wait",  0,  0,  0,  0, 0, 0, 0, 0, 0, 0, 1, 0, C_MEMW);
        applyStimulus("to_pulse",     0,  0,  0,  0, 0, 0, 0, 0, 0, 0, 1, 0, C_TO);
        applyStimulus("to_after",     0,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE);

        applyStimulus("mm_start",     0,  0,  0,  0, 0, 0, 0, 0, 1, 0, 0, 0, C_MDU);
        applyStimulus("mm_memw",      0,  0,  0,  0, 0, 0, 0, 0, 0, 0, 1, 0, C_MEMW);
        applyStimulus("mm_memw_done", 0,  0,  0,  0, 0, 0, 0, 0, 0, 1, 1, 0, C_MEMW);
        applyStimulus("mm_release",   0,  0,  0,  0, 0, 0, 0, 0, 0, 1, 1, 1, C_NONE);
        applyStimulus("mm_after",     0,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE);

        applyStimulus("mm2_start",    0,  0,  0,  0, 0, 0, 0, 0, 1, 0, 0, 0, C_MDU);
        applyStimulus("mm2_memw",     0,  0,  0,  0, 0, 0, 0, 0, 0, 0, 1, 0, C_MEMW);
        applyStimulus("mm2_release",  0,  0,  0,  0, 0, 0, 0, 0, 0, 0, 1, 1, C_MDU);
        applyStimulus("mm2_done",     0,  0,  0,  0, 0, 0, 0, 0, 0, 1, 0, 0, C_NONE);

        applyStimulus("bm_memw",      0,  0,  0,  0, 0, 0, 0, 1, 0, 0, 1, 0, C_MEMW);
        applyStimulus("bm_release",   0,  0,  0,  0, 0, 0, 0, 1, 0, 0, 1, 1, C_BR);
        applyStimulus("bm_after",     0,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE);

        applyStimulus("rm_start",     0,  0,  0,  0, 0, 0, 0, 0, 1, 0, 0, 0, C_MDU);
        applyStimulus("rm_wait",      0,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, C_MDU);
        applyStimulus("rm_rst0",      1,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST);
        applyStimulus("rm_rst1",      1,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST);
        applyStimulus("rm_done_ign",  0,  0,  0,  0, 0, 0, 0, 0, 0, 1, 0, 0, C_NONE);
        applyStimulus("rm_idle",      0,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE);

        @(negedge clk);
        #1;
        checkOutput("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline (IF, ID, EX, MEM, WB); it sits beside the operand forwarding unit.
- Detects load-use hazards that forwarding cannot cover.
- Redirects on taken branches and jumps.
- Freezes the pipe for multi-cycle MUL/DIV operations and data-memory wait states.
- Drives hold/bubble controls for every pipeline register.
- A small FSM tracks MDU and memory waits and enforces a memory timeout.

Parameters:
REG_W, 5, register index width
MEM_TIMEOUT, 255, max consecutive MEM_WAIT cycles before abort (>=2)
CNT_W, 32, width of the optional performance counters

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
rs1_id, rs2_id  in  REG_W  source registers of the instruction in ID
use_rs1_id, use_rs2_id  in  1  ID instruction actually reads rs1/rs2
rd_ex  in  REG_W  destination register of the instruction in EX
memread_ex  in  1  EX instruction is a load
branch_taken_ex  in  1  EX resolved a taken branch or jump (PC redirect)
mdu_start_ex  in  1  multi-cycle MUL/DIV issued in EX this cycle
mdu_done  in  1  MDU result valid
dmem_req_mem  in  1  MEM stage accessing data memory
dmem_ready  in  1  data memory completes the access this cycle
pc_stall, if_id_stall, id_ex_stall, ex_mem_stall  out  1  hold the register
if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1  load a bubble (NOP, control bits cleared)
mem_timeout  out  1  one-cycle abort pulse
cnt_loaduse, cnt_flush, cnt_stall  out  CNT_W  performance counters

Behaviour:
- FSM states RUN, MDU_WAIT, MEM_WAIT. State, wait counter and counters are registered. Stall/flush outputs are combinational from state and inputs, so they take effect the same cycle.
- Reset asserted: next state RUN, wait counter 0, counters 0, mem_timeout 0, all stalls 0. if_id_flush, id_ex_flush, ex_mem_flush and mem_wb_flush are 1 (the pipe is cleared). A reset mid-wait abandons the MDU or memory operation.
- Priority each cycle: memory wait > MDU > branch > load-use > none. Only the highest-priority action is applied.
- Memory wait, when dmem_req_mem=1 and dmem_ready=0:
  - Asserts pc/if_id/id_ex/ex_mem stall and mem_wb_flush.
  - RUN transitions to MEM_WAIT with the counter set to 1. In MEM_WAIT the counter increments each cycle.
  - When dmem_ready=1: no stalls that cycle, return to RUN, counter cleared.
  - If the counter reaches MEM_TIMEOUT with dmem_ready still 0: that cycle pulse mem_timeout=1, assert ex_mem_flush and mem_wb_flush, release all stalls, and return to RUN.
- MDU, entered from RUN when mdu_start_ex=1:
  - Start cycle: assert pc/if_id/id_ex stall and ex_mem_flush; go to MDU_WAIT.
  - MDU_WAIT with mdu_done=0: same outputs, stay.
  - MDU_WAIT with mdu_done=1: no stalls, so the result enters EX/MEM; return to RUN.
  - mdu_done is ignored outside MDU_WAIT.
  - A memory wait arising during MDU_WAIT has priority for those cycles; the MDU state is held and mdu_done is not lost, because the MDU keeps it asserted until EX advances.
- Branch (RUN, no higher event): if_id_flush=1, id_ex_flush=1, no stalls; the PC loads the target. This gives a 2-cycle penalty.
- Load-use (RUN, no higher event): condition is memread_ex, rd_ex!=0, and (rd_ex==rs1_id with use_rs1_id, or rd_ex==rs2_id with use_rs2_id). Response: pc_stall=1, if_id_stall=1, id_ex_flush=1. This inserts exactly one bubble; the WB forwarding path then covers the dependency.
- Branch coincident with load-use: the branch wins and there is no stall.
- A branch or load-use held behind a memory wait is re-evaluated after release, because its inputs persist.
- Stall and flush are never asserted on the same pipeline register in the same cycle.

Optional Feature:
PIPE_PERF_CNT_EN
- Defined:
  - cnt_loaduse increments on each load-use bubble.
  - cnt_flush increments on each branch redirect.
  - cnt_stall increments on each cycle pc_stall=1.
  - All counters saturate at all-ones and clear on reset.
- Undefined: the counter ports remain and are tied to 0; no counter logic is built.

Decomposition:
- Package pipe_ctrl_pkg: state enum (RUN, MDU_WAIT, MEM_WAIT) and the REG_W default constant.
- Sub-module load_use_detect: the combinational rd/rs compare producing load_use. It is also reusable for the x0 guard.

Test Plan:
- Load-use: lw x5 in EX (rd_ex=5, memread_ex=1), rs1_id=5, use_rs1_id=1 -> one cycle of pc_stall=1, if_id_stall=1, id_ex_flush=1; next cycle all 0. The same case with rd_ex=0 gives no stall.
- Branch: branch_taken_ex=1 with a load-use condition also true -> if_id_flush=id_ex_flush=1, pc_stall=0, cnt_flush+1.
- MDU: mdu_start_ex=1, mdu_done raised 4 cycles later -> pc/if_id/id_ex stall=1 and ex_mem_flush=1 for 4 cycles; 5th cycle all 0; state back to RUN.
- Memory wait: dmem_req_mem=1, dmem_ready=0 for 3 cycles then 1 -> four stalls plus mem_wb_flush for 3 cycles; released on the ready cycle; mem_timeout stays 0.
- Timeout (MEM_TIMEOUT=4): dmem_ready never asserted -> after 4 wait cycles mem_timeout pulses 1 cycle with ex_mem_flush=mem_wb_flush=1; state RUN.
- Reset asserted during MDU_WAIT -> next cycle state RUN, all four flushes 1 while reset held, counters 0; a later mdu_done is ignored.
